// File: rtl/rv_pkg.sv
// ============================================================================
// Module   : rv_pkg
// Purpose  : Shared writeback types and widths for the register-file port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LSU  = 2'd2
  } wb_grant_e;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module   : wb_fifo
// Purpose  : LSU result buffer with per-entry valid bits and squash-by-rd.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  input  logic                  squash_en,
  input  logic [REG_ADDR_W-1:0] squash_rd,
  output wb_entry_t             head,
  output logic                  full,
  output logic                  empty,
  output logic                  any_vld
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]      vld_q;
  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [XLEN-1:0]       data_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign any_vld = |vld_q;

  always_comb begin
    head      = '0;
    head.vld  = vld_q[rd_ptr] && !empty;
    head.rd   = rd_q[rd_ptr];
    head.data = data_q[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Push targets a free slot and pop the occupied head, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == PTR_W'(i))) begin
          vld_q[i] <= push_entry.vld;
        end else if (pop && (rd_ptr == PTR_W'(i))) begin
          vld_q[i] <= 1'b0;
        end else if (squash_en && (rd_q[i] == squash_rd)) begin
          vld_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr == PTR_W'(i))) begin
        rd_q[i]   <= push_entry.rd;
        data_q[i] <= push_entry.data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Shares the register-file write port between ALU and buffered LSU.
//            WB_STARVE_GUARD_EN enables the LSU starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter
  import rv_pkg::*;
#(
  parameter int LSU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_stall,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  lsu_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  lsu_busy
);

  wb_entry_t head;
  wb_entry_t push_entry;
  wb_grant_e grant;
  logic      full;
  logic      empty;
  logic      any_vld;
  logic      push;
  logic      pop;
  logic      squash_en;
  logic      force_lsu;
  logic      alu_wr_req;

  assign alu_wr_req = alu_valid && (alu_rd != '0);
  assign lsu_ready  = rst_n && !full;
  assign lsu_busy   = rst_n && any_vld;

`ifdef WB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign force_lsu = (starve_cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if ((grant == GNT_LSU) || !any_vld) begin
      starve_cnt <= '0;
    end else if (head.vld && !force_lsu) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_lsu = 1'b0;
`endif

  // Gating on rst_n keeps the port silent while reset is held.
  always_comb begin
    grant     = GNT_NONE;
    alu_stall = 1'b0;
    if (rst_n) begin
      if (force_lsu && head.vld) begin
        grant     = GNT_LSU;
        alu_stall = 1'b1;
      end else if (head.vld && !alu_wr_req) begin
        grant = GNT_LSU;
      end else if (alu_wr_req) begin
        grant = GNT_ALU;
      end
    end
  end

  // Squashed heads drain silently alongside whatever else is granted.
  assign pop       = (grant == GNT_LSU) || (!empty && !head.vld);
  assign squash_en = (grant == GNT_ALU);

  // rd==0 results and results overwritten by this cycle's ALU write are dropped.
  assign push = lsu_valid && lsu_ready && (lsu_rd != '0) &&
                !(squash_en && (lsu_rd == alu_rd));

  always_comb begin
    push_entry      = '0;
    push_entry.vld  = 1'b1;
    push_entry.rd   = lsu_rd;
    push_entry.data = lsu_data;
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = alu_rd;
    rf_wdata = alu_data;
    if (grant == GNT_LSU) begin
      rf_we    = 1'b1;
      rf_rd    = head.rd;
      rf_wdata = head.data;
    end else if (grant == GNT_ALU) begin
      rf_we = 1'b1;
    end
  end

  wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .squash_en  (squash_en),
    .squash_rd  (alu_rd),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .any_vld    (any_vld)
  );

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed self-checking bench for wb_arbiter (DEPTH=2, LIMIT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        lsu_busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .LSU_FIFO_DEPTH (2),
    .STARVE_LIMIT   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .lsu_busy  (lsu_busy)
  );

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    alu_valid = av;  alu_rd = ard;  alu_data = ad;
    lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ld;
  endtask

  task automatic check(input string tag, input logic e_we, input logic [4:0] e_rd,
                       input logic [31:0] e_wd, input logic e_st, input logic e_rdy,
                       input logic e_bsy);
    logic [40:0] obs;
    logic [40:0] exp;
    obs = {rf_we, rf_rd, rf_wdata, alu_stall, lsu_ready, lsu_busy};
    exp = {e_we, e_rd, e_wd, e_st, e_rdy, e_bsy};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed we=%b rd=%0d wdata=%h stall=%b ready=%b busy=%b, expected we=%b rd=%0d wdata=%h stall=%b ready=%b busy=%b",
             tag, obs[40], obs[39:35], obs[34:3], obs[2], obs[1], obs[0],
             e_we, e_rd, e_wd, e_st, e_rdy, e_bsy);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 5'd5, 32'h11, 0, 5'd0, 32'h0);
    @(negedge clk);
    check("reset_hold", 0, 5'd5, 32'h11, 0, 0, 0);
    next_cycle();
    rst_n = 1'b1;

    drive(1, 5'd5, 32'h11, 0, 5'd0, 32'h0);  @(negedge clk);
    check("alu_rd5", 1, 5'd5, 32'h11, 0, 1, 0);               next_cycle();
    drive(1, 5'd0, 32'h22, 0, 5'd0, 32'h0);  @(negedge clk);
    check("alu_rd0", 0, 5'd0, 32'h22, 0, 1, 0);               next_cycle();

    drive(0, 5'd0, 32'h0, 1, 5'd7, 32'hAB);  @(negedge clk);
    check("lsu_enq", 0, 5'd0, 32'h0, 0, 1, 0);                next_cycle();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);   @(negedge clk);
    check("lsu_write", 1, 5'd7, 32'hAB, 0, 1, 1);             next_cycle();
    @(negedge clk);
    check("lsu_idle", 0, 5'd0, 32'h0, 0, 1, 0);               next_cycle();

    drive(1, 5'd1, 32'h101, 1, 5'd8, 32'hC1); @(negedge clk);
    check("fill_0", 1, 5'd1, 32'h101, 0, 1, 0);               next_cycle();
    drive(1, 5'd1, 32'h102, 1, 5'd9, 32'hC2); @(negedge clk);
    check("fill_1", 1, 5'd1, 32'h102, 0, 1, 1);               next_cycle();
    drive(1, 5'd1, 32'h103, 1, 5'd10, 32'hC3); @(negedge clk);
    check("fill_full", 1, 5'd1, 32'h103, 0, 0, 1);            next_cycle();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);   @(negedge clk);
    check("drain_0", 1, 5'd8, 32'hC1, 0, 0, 1);               next_cycle();
    @(negedge clk);
    check("drain_1", 1, 5'd9, 32'hC2, 0, 1, 1);               next_cycle();
    @(negedge clk);
    check("drain_done", 0, 5'd0, 32'h0, 0, 1, 0);             next_cycle();

    drive(0, 5'd0, 32'h0, 1, 5'd3, 32'hA);   @(negedge clk);
    check("sq_enq", 0, 5'd0, 32'h0, 0, 1, 0);                 next_cycle();
    drive(1, 5'd3, 32'hB, 0, 5'd0, 32'h0);   @(negedge clk);
    check("sq_alu", 1, 5'd3, 32'hB, 0, 1, 1);                 next_cycle();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);   @(negedge clk);
    check("sq_pop", 0, 5'd0, 32'h0, 0, 1, 0);                 next_cycle();
    @(negedge clk);
    check("sq_empty", 0, 5'd0, 32'h0, 0, 1, 0);               next_cycle();

    drive(1, 5'd4, 32'h44, 1, 5'd4, 32'h55); @(negedge clk);
    check("sq_incoming", 1, 5'd4, 32'h44, 0, 1, 0);           next_cycle();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);   @(negedge clk);
    check("sq_incoming_gone", 0, 5'd0, 32'h0, 0, 1, 0);       next_cycle();

    drive(0, 5'd0, 32'h0, 1, 5'd0, 32'h66);  @(negedge clk);
    check("lsu_rd0", 0, 5'd0, 32'h0, 0, 1, 0);                next_cycle();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);   @(negedge clk);
    check("lsu_rd0_gone", 0, 5'd0, 32'h0, 0, 1, 0);           next_cycle();

    drive(0, 5'd0, 32'h0, 1, 5'd12, 32'h77); @(negedge clk);
    check("rd0_enq", 0, 5'd0, 32'h0, 0, 1, 0);                next_cycle();
    drive(1, 5'd0, 32'h88, 0, 5'd0, 32'h0);  @(negedge clk);
    check("alu_rd0_lsu", 1, 5'd12, 32'h77, 0, 1, 1);          next_cycle();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);   @(negedge clk);
    check("alu_rd0_done", 0, 5'd0, 32'h0, 0, 1, 0);           next_cycle();

    drive(1, 5'd2, 32'h201, 1, 5'd6, 32'h61); @(negedge clk);
    check("starve_enq", 1, 5'd2, 32'h201, 0, 1, 0);           next_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'd2, 32'h202 + 32'(k), 0, 5'd0, 32'h0); @(negedge clk);
      check("starve_deny", 1, 5'd2, 32'h202 + 32'(k), 0, 1, 1); next_cycle();
    end
    drive(1, 5'd2, 32'h206, 0, 5'd0, 32'h0); @(negedge clk);
`ifdef WB_STARVE_GUARD_EN
    check("starve_force", 1, 5'd6, 32'h61, 1, 1, 1);          next_cycle();
    @(negedge clk);
    check("starve_alu_retry", 1, 5'd2, 32'h206, 0, 1, 0);     next_cycle();
`else
    check("no_guard_alu", 1, 5'd2, 32'h206, 0, 1, 1);         next_cycle();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);   @(negedge clk);
    check("no_guard_drain", 1, 5'd6, 32'h61, 0, 1, 1);        next_cycle();
`endif
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);   @(negedge clk);
    check("starve_done", 0, 5'd0, 32'h0, 0, 1, 0);            next_cycle();

    drive(1, 5'd1, 32'h301, 1, 5'd13, 32'hD1); @(negedge clk);
    check("rst_q0", 1, 5'd1, 32'h301, 0, 1, 0);               next_cycle();
    drive(1, 5'd1, 32'h302, 1, 5'd14, 32'hD2); @(negedge clk);
    check("rst_q1", 1, 5'd1, 32'h302, 0, 1, 1);               next_cycle();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_drain", 0, 5'd0, 32'h0, 0, 0, 0);          next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release", 0, 5'd0, 32'h0, 0, 1, 0);            next_cycle();
    drive(1, 5'd9, 32'h99, 0, 5'd0, 32'h0);  @(negedge clk);
    check("post_rst_alu", 1, 5'd9, 32'h99, 0, 1, 0);          next_cycle();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);   @(negedge clk);
    check("post_rst_idle", 0, 5'd0, 32'h0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the register file's single write port (rf_we/rf_rd/rf_wdata) between the in-order ALU writeback stage and the load/store unit (LSU). The ALU has priority. LSU results are buffered in a small FIFO and drained in ALU-idle cycles. Queued loads made stale by a younger ALU write are squashed. An optional starvation guard stalls the ALU to force an LSU drain. The block sits between the execute/memory stages and the register file; the register file's same-cycle bypass makes every granted write visible to readers in the grant cycle.

## Interface
- LSU_FIFO_DEPTH, 2: LSU result buffer entries; power of two, ≥2
- STARVE_LIMIT, 4: consecutive denied cycles before the LSU head is forced; 1..15
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_stall  out  1  ALU result not taken; ALU holds valid/rd/data
- lsu_valid  in  1  LSU result offered
- lsu_rd  in  5  LSU destination register
- lsu_data  in  32  LSU result
- lsu_ready  out  1  FIFO can accept; transfer on lsu_valid && lsu_ready
- rf_we  out  1  register file write enable
- rf_rd  out  5  register file write address
- rf_wdata  out  32  register file write data
- lsu_busy  out  1  at least one valid LSU entry queued (to hazard unit)

## Operation
- FIFO entry: {vld, rd, data}. State: FIFO pointers/count, entry valid bits, starvation counter (4 bits).
- Enqueue: on lsu_valid && lsu_ready. An incoming entry with lsu_rd==0 is accepted and discarded.
- lsu_ready = !full; it depends only on registered state, never on lsu_valid.
- Head invalid (squashed): popped silently this cycle with no write; does not block the ALU.
- Grant per cycle, in priority order:
  - (1) force active (guard only) and head valid: LSU writes, alu_stall=1.
  - (2) head valid and (!alu_valid or alu_rd==0): LSU writes, head popped.
  - (3) alu_valid and alu_rd!=0: ALU writes.
  - (4) otherwise rf_we=0.
- alu_valid with alu_rd==0 is consumed with no write; alu_stall=0 unless force.
- Squash: every ALU write is younger than every queued or incoming LSU entry (hazard unit contract). When the ALU writes rd=R, all queued entries with rd==R are invalidated, and an LSU entry with rd==R enqueued in the same cycle is dropped.
- rf_rd/rf_wdata are driven from the granted source. When rf_we=0 they carry the ALU inputs.
- Starvation counter: increments when head valid and the LSU is not granted. Clears on LSU grant or when no valid entry is queued. Force = counter==STARVE_LIMIT.
- lsu_busy = any entry with vld=1.

## Timing
- rf_we/rf_rd/rf_wdata/alu_stall are combinational from inputs and registered state, so an ALU write occurs in its arrival cycle.
- LSU minimum latency: enqueue at edge N, write in cycle N+1 (no flow-through into an empty FIFO).
- Full FIFO: lsu_ready=0. Enqueue and pop in the same cycle are legal only when not full.
- Reset (asynchronous, any time including mid-drain): FIFO emptied, counter=0. While rst_n=0: rf_we=0, alu_stall=0, lsu_ready=0, lsu_busy=0. lsu_ready=1 in the first cycle after release.
- Pointer wrap is modulo LSU_FIFO_DEPTH. Count is $clog2(DEPTH)+1 bits.

## Configuration
- WB_STARVE_GUARD_EN defined: starvation counter and force rule (1) present. The LSU head is written within STARVE_LIMIT+1 cycles of becoming head.
- Undefined: counter absent, alu_stall tied 0. The LSU drains only in cycles without a nonzero-rd ALU write.

## Structure
- Shared package rv_pkg: XLEN=32, REG_ADDR_W=5, wb_entry_t {vld, rd, data}.
- One sub-module, wb_fifo: storage, pointers, full/empty, per-entry squash-by-rd port. The arbiter keeps grant logic and the counter.

## Test plan
- ALU only: alu_valid=1, rd=5, data=0x11 → rf_we=1, rf_rd=5, rf_wdata=0x11 same cycle. alu_rd=0 → rf_we=0, alu_stall=0.
- LSU only: rd=7, data=0xAB enqueued at edge N → rf_we=1, rf_rd=7 in cycle N+1; lsu_busy falls after N+1.
- Fill: DEPTH=2, ALU busy with rd=1 every cycle, guard off → lsu_ready=0 after two enqueues. The FIFO drains in order on the first ALU-idle cycles.
- Squash: queue rd=3 data=0xA; ALU writes rd=3 data=0xB → only 0xB is written; the squashed entry is popped without a write; lsu_busy=0.
- Guard on, STARVE_LIMIT=4, ALU writes rd=2 every cycle with an LSU entry queued → on the 5th cycle: alu_stall=1, LSU written. The ALU result is written the next cycle.
- Reset asserted mid-drain with 2 entries queued → all outputs 0 immediately. No stale write after release.
